mem_port_arbiter: RTL and testbench

- Shares the single 256x8 negedge-clocked external memory between two requesters: port 0 (MIPS core) and port 1 (loader/debug).
- Arbitrates between the two, registers the winning address, write enable and write data onto the memory pins, and captures read data.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between the core and the memory model; it is the only driver of the memory's memwrite, adr and writedata inputs.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes, status and memory pins around the arbiter.
//
// Handshake: a requester raises pN_req with pN_we/pN_adr/pN_wdata stable and
// holds them until it sees pN_ack. pN_ack is a single-cycle pulse marking
// completion; rdata is valid in that same cycle for reads. A requester may
// raise req again in the cycle after ack; the arbiter only samples requests
// in IDLE.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_adr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_adr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;

    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              gnt_id;

    logic              mem_memwrite;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_memdata;

    // Requesters and memory model side.
    modport master (
        output p0_req, p0_we, p0_adr, p0_wdata,
        output p1_req, p1_we, p1_adr, p1_wdata,
        output mem_memdata,
        input  p0_ack, p1_ack, rdata, busy, gnt_id,
        input  mem_memwrite, mem_adr, mem_writedata
    );

    // Arbiter side.
    modport slave (
        input  p0_req, p0_we, p0_adr, p0_wdata,
        input  p1_req, p1_we, p1_adr, p1_wdata,
        input  mem_memdata,
        output p0_ack, p1_ack, rdata, busy, gnt_id,
        output mem_memwrite, mem_adr, mem_writedata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way winner picker: round-robin or fixed priority.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic       win_id,
    output logic       win_valid
);

    // Single requester wins outright; a tie goes to port 0 in fixed mode,
    // otherwise to whichever port did not win last time.
    always_comb begin
        win_valid = |req;
        win_id    = PORT_CPU;
        if (req == 2'b11) begin
            win_id = fixed_prio ? PORT_CPU : ~last_gnt;
        end else if (req[1]) begin
            win_id = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one negedge-sampled 256x8 memory between the core (port 0) and the
// loader/debug port (port 1). One access takes IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output mem_arb_pkg::state_t dbg_state
);
    import mem_arb_pkg::*;

    state_t            state_q;
    state_t            state_d;

    logic [1:0]        req;
    logic              pick_id;
    logic              pick_valid;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;

    logic              last_gnt_q;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;

    assign req = {bus.p1_req, bus.p0_req};

    rr_pick2 u_pick (
        .req        (req),
        .last_gnt   (last_gnt_q),
        .fixed_prio (FIXED_PRIO != 0),
        .win_id     (pick_id),
        .win_valid  (pick_valid)
    );

    // Winner's command fields, selected by the picker.
    always_comb begin
        sel_we    = bus.p0_we;
        sel_adr   = bus.p0_adr;
        sel_wdata = bus.p0_wdata;
        if (pick_id == PORT_LDR) begin
            sel_we    = bus.p1_we;
            sel_adr   = bus.p1_adr;
            sel_wdata = bus.p1_wdata;
        end
    end

    // State register; reset returns to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arbitrate only in IDLE, ACCESS and RESP last one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered memory pins, read capture, acks and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= PORT_LDR;
            gnt_q      <= PORT_CPU;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Address/data hold their last values while nobody asks.
                    if (pick_valid) begin
                        adr_q   <= sel_adr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        gnt_q   <= pick_id;
                        busy_q  <= 1'b1;
                    end else begin
                        we_q    <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Memory acted on the negedge inside this cycle.
                    rdata_q    <= bus.mem_memdata;
                    we_q       <= 1'b0;
                    ack0_q     <= (gnt_q == PORT_CPU);
                    ack1_q     <= (gnt_q == PORT_LDR);
                    last_gnt_q <= gnt_q;
                end
                RESP: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    we_q   <= 1'b0;
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_memwrite  = we_q;
    assign bus.mem_adr       = adr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.rdata         = rdata_q;
    assign bus.p0_ack        = ack0_q;
    assign bus.p1_ack        = ack1_q;
    assign bus.busy          = busy_q;
    assign bus.gnt_id        = gnt_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table on a round-robin instance,
// hand sequences for fixed priority, request drop and mid-access reset.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t state_r;
    state_t state_f;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_r ();
    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_f ();

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_r.slave),
        .dbg_state (state_r)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_f (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_f.slave),
        .dbg_state (state_f)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge memory models: read old contents, then write
    logic [7:0] mem_r [256];
    logic [7:0] mem_f [256];
    logic       pre_en;
    logic [7:0] pre_adr;
    logic [7:0] pre_data;

    always @(negedge clk) begin
        if (pre_en) begin
            mem_r[pre_adr] <= pre_data;
        end else begin
            bus_r.mem_memdata <= mem_r[bus_r.mem_adr];
            if (bus_r.mem_memwrite) mem_r[bus_r.mem_adr] <= bus_r.mem_writedata;
        end
    end

    always @(negedge clk) begin
        if (pre_en) begin
            mem_f[pre_adr] <= pre_data;
        end else begin
            bus_f.mem_memdata <= mem_f[bus_f.mem_adr];
            if (bus_f.mem_memwrite) mem_f[bus_f.mem_adr] <= bus_f.mem_writedata;
        end
    end

    logic [7:0] pl_a [6] = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF};
    logic [7:0] pl_d [6] = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle vector: inputs before a posedge, expected outputs after it
    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        state_t     st;
        logic       ack0, ack1, mw;
        logic [7:0] adr;
        logic       gnt, busy, rc;
        logic [7:0] rd;
    } vec_t;

    function automatic vec_t v(
        input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
        input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
        input state_t st, input logic ack0, input logic ack1, input logic mw,
        input logic [7:0] adr, input logic gnt, input logic busy,
        input logic rc, input logic [7:0] rd);
        vec_t x;
        x.r0 = r0; x.w0 = w0; x.a0 = a0; x.d0 = d0;
        x.r1 = r1; x.w1 = w1; x.a1 = a1; x.d1 = d1;
        x.st = st; x.ack0 = ack0; x.ack1 = ack1; x.mw = mw;
        x.adr = adr; x.gnt = gnt; x.busy = busy; x.rc = rc; x.rd = rd;
        return x;
    endfunction

    vec_t vecs [20];

    task automatic drive_r(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                           input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        bus_r.p0_req = r0; bus_r.p0_we = w0; bus_r.p0_adr = a0; bus_r.p0_wdata = d0;
        bus_r.p1_req = r1; bus_r.p1_we = w1; bus_r.p1_adr = a1; bus_r.p1_wdata = d1;
    endtask

    task automatic drive_f(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
        bus_f.p0_req = r0; bus_f.p0_we = 1'b0; bus_f.p0_adr = a0; bus_f.p0_wdata = 8'h00;
        bus_f.p1_req = r1; bus_f.p1_we = 1'b0; bus_f.p1_adr = a1; bus_f.p1_wdata = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n0;
    int n1;

    initial begin
        // Vector table: read, write then read-back at 0xFF, round-robin tie run
        vecs[0]  = v(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, ACCESS,0,0,0,8'h05,0,1,0,8'h00);
        vecs[1]  = v(1,0,8'h05,8'h00, 0,0,8'h00,8'h00, RESP,  1,0,0,8'h05,0,1,1,8'h3C);
        vecs[2]  = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'h05,0,0,1,8'h3C);
        vecs[3]  = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'h05,0,0,0,8'h00);
        vecs[4]  = v(0,0,8'h00,8'h00, 1,1,8'hFF,8'hA5, ACCESS,0,0,1,8'hFF,1,1,0,8'h00);
        vecs[5]  = v(0,0,8'h00,8'h00, 1,1,8'hFF,8'hA5, RESP,  0,1,0,8'hFF,1,1,0,8'h00);
        vecs[6]  = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'hFF,1,0,0,8'h00);
        vecs[7]  = v(0,0,8'h00,8'h00, 1,0,8'hFF,8'h00, ACCESS,0,0,0,8'hFF,1,1,0,8'h00);
        vecs[8]  = v(0,0,8'h00,8'h00, 1,0,8'hFF,8'h00, RESP,  0,1,0,8'hFF,1,1,1,8'hA5);
        vecs[9]  = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'hFF,1,0,1,8'hA5);
        vecs[10] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, ACCESS,0,0,0,8'h10,0,1,0,8'h00);
        vecs[11] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, RESP,  1,0,0,8'h10,0,1,1,8'h11);
        vecs[12] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, IDLE,  0,0,0,8'h10,0,0,1,8'h11);
        vecs[13] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, ACCESS,0,0,0,8'h20,1,1,0,8'h00);
        vecs[14] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, RESP,  0,1,0,8'h20,1,1,1,8'h22);
        vecs[15] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, IDLE,  0,0,0,8'h20,1,0,1,8'h22);
        vecs[16] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, ACCESS,0,0,0,8'h10,0,1,0,8'h00);
        vecs[17] = v(1,0,8'h10,8'h00, 1,0,8'h20,8'h00, RESP,  1,0,0,8'h10,0,1,1,8'h11);
        vecs[18] = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'h10,0,0,1,8'h11);
        vecs[19] = v(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, IDLE,  0,0,0,8'h10,0,0,0,8'h00);

        rst_n  = 1'b0;
        pre_en = 1'b0; pre_adr = 8'h00; pre_data = 8'h00;
        drive_r(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
        drive_f(0,8'h00, 0,8'h00);

        // Reset state of both instances
        #2;
        chk("rst state_r", state_r, IDLE);
        chk("rst memwrite_r", bus_r.mem_memwrite, 0);
        chk("rst adr_r", bus_r.mem_adr, 0);
        chk("rst wdata_r", bus_r.mem_writedata, 0);
        chk("rst rdata_r", bus_r.rdata, 0);
        chk("rst acks_r", {bus_r.p0_ack, bus_r.p1_ack}, 0);
        chk("rst busy_gnt_r", {bus_r.busy, bus_r.gnt_id}, 0);
        chk("rst state_f", state_f, IDLE);
        chk("rst outs_f", {bus_f.mem_memwrite, bus_f.p0_ack, bus_f.p1_ack, bus_f.busy, bus_f.gnt_id}, 0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            pre_en = 1'b1; pre_adr = pl_a[i]; pre_data = pl_d[i];
        end
        @(posedge clk);
        pre_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven cycles on the round-robin instance
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_r(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            tick();
            chk($sformatf("v%0d state", i), state_r, vecs[i].st);
            chk($sformatf("v%0d p0_ack", i), bus_r.p0_ack, vecs[i].ack0);
            chk($sformatf("v%0d p1_ack", i), bus_r.p1_ack, vecs[i].ack1);
            chk($sformatf("v%0d memwrite", i), bus_r.mem_memwrite, vecs[i].mw);
            chk($sformatf("v%0d mem_adr", i), bus_r.mem_adr, vecs[i].adr);
            chk($sformatf("v%0d gnt_id", i), bus_r.gnt_id, vecs[i].gnt);
            chk($sformatf("v%0d busy", i), bus_r.busy, vecs[i].busy);
            if (vecs[i].rc) chk($sformatf("v%0d rdata", i), bus_r.rdata, vecs[i].rd);
        end

        // Fixed priority: both requesting, only port 0 is served
        @(negedge clk);
        drive_f(1, 8'h30, 1, 8'h40);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_f.p0_ack) n0++;
            if (bus_f.p1_ack) n1++;
        end
        chk("fixed p0 acks", n0, 3);
        chk("fixed p1 acks", n1, 0);
        chk("fixed state in RESP", state_f, RESP);
        chk("fixed p0 rdata", bus_f.rdata, 8'h33);
        @(negedge clk);
        bus_f.p0_req = 1'b0;
        tick();
        chk("fixed back to IDLE", state_f, IDLE);
        tick();
        chk("fixed p1 granted", {state_f, bus_f.gnt_id}, {ACCESS, 1'b1});
        tick();
        chk("fixed p1 ack", {bus_f.p0_ack, bus_f.p1_ack}, 2'b01);
        chk("fixed p1 rdata", bus_f.rdata, 8'h44);
        @(negedge clk);
        bus_f.p1_req = 1'b0;

        // Request dropped during ACCESS still completes
        @(negedge clk);
        drive_r(1,0,8'h05,8'h00, 0,0,8'h00,8'h00);
        tick();
        chk("abort in ACCESS", state_r, ACCESS);
        @(negedge clk);
        bus_r.p0_req = 1'b0;
        tick();
        chk("abort p0_ack", bus_r.p0_ack, 1);
        chk("abort rdata", bus_r.rdata, 8'h3C);
        tick();
        chk("abort idle", state_r, IDLE);

        // Reset in the middle of a port 1 write
        @(negedge clk);
        drive_r(0,0,8'h00,8'h00, 1,1,8'h50,8'h77);
        tick();
        chk("mid-rst write active", bus_r.mem_memwrite, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst memwrite drops", bus_r.mem_memwrite, 0);
        chk("mid-rst state", state_r, IDLE);
        chk("mid-rst busy", bus_r.busy, 0);
        bus_r.p1_req = 1'b0;
        tick();
        chk("mid-rst no ack", {bus_r.p0_ack, bus_r.p1_ack}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst no ack", {bus_r.p0_ack, bus_r.p1_ack, state_r}, {2'b00, IDLE});
        @(negedge clk);
        drive_r(1,0,8'h05,8'h00, 1,0,8'h20,8'h00);
        tick();
        chk("post-rst tie to p0", {state_r, bus_r.gnt_id}, {ACCESS, 1'b0});
        tick();
        chk("post-rst p0 ack", {bus_r.p0_ack, bus_r.p1_ack}, 2'b10);
        chk("post-rst rdata", bus_r.rdata, 8'h3C);
        @(negedge clk);
        drive_r(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
        tick();

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
